mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the 64 x 15-bit sensor sample memory.
- Shares that memory between a writer (sample capture path, which stores 15-bit flex/IMU words) and a reader (gesture classifier).
- Generates the memory's address, data-in, read/write and chip-select controls, and returns registered read data with a valid pulse.
- Round-robin arbitration, so neither requester starves.

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Handshake and memory-side bus between the sample requesters, the arbiter and
// the 64 x 15-bit sample memory.
interface mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 15
);
    logic          W_REQ;
    logic [AW-1:0] W_ADD;
    logic [DW-1:0] W_DATA;
    logic          W_ACK;
    logic          R_REQ;
    logic [AW-1:0] R_ADD;
    logic          R_ACK;
    logic          R_VALID;
    logic [DW-1:0] R_DATA;
    logic          BUSY;
    logic [AW-1:0] MEM_ADD;
    logic [DW-1:0] MEM_DIN;
    logic          MEM_RW;
    logic          MEM_CS;
    logic [DW-1:0] MEM_DOUT;

    // master: requesters plus memory; slave: the arbiter
    modport master (
        output W_REQ, W_ADD, W_DATA, R_REQ, R_ADD, MEM_DOUT,
        input  W_ACK, R_ACK, R_VALID, R_DATA, BUSY, MEM_ADD, MEM_DIN, MEM_RW, MEM_CS
    );
    modport slave (
        input  W_REQ, W_ADD, W_DATA, R_REQ, R_ADD, MEM_DOUT,
        output W_ACK, R_ACK, R_VALID, R_DATA, BUSY, MEM_ADD, MEM_DIN, MEM_RW, MEM_CS
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin writer/reader arbiter and command sequencer for the sensor sample memory.
// All outputs are registered; read data returns RD_LAT+2 cycles after the grant.
//
//   state | meaning
//   IDLE  | sample W_REQ/R_REQ, grant one (round-robin on a tie)
//   WR    | write command on the memory bus, W_ACK high
//   RD    | read command on the memory bus, R_ACK high
//   RWAIT | memory latency; down-counter reaches zero on the data-capture cycle
module mem_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 15,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int CW = 2;

    typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_t;

    state_t        state_q, state_d;
    logic          last_rd_q, last_rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_w, grant_r;

    logic          w_ack_q, w_ack_d;
    logic          r_ack_q, r_ack_d;
    logic          r_valid_q, r_valid_d;
    logic [DW-1:0] r_data_q, r_data_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] mem_add_q, mem_add_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_rw_q, mem_rw_d;
    logic          mem_cs_q, mem_cs_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b1;
            cnt_q     <= '0;
            w_ack_q   <= 1'b0;
            r_ack_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            busy_q    <= 1'b0;
            mem_add_q <= '0;
            mem_din_q <= '0;
            mem_rw_q  <= 1'b0;
            mem_cs_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            cnt_q     <= cnt_d;
            w_ack_q   <= w_ack_d;
            r_ack_q   <= r_ack_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            busy_q    <= busy_d;
            mem_add_q <= mem_add_d;
            mem_din_q <= mem_din_d;
            mem_rw_q  <= mem_rw_d;
            mem_cs_q  <= mem_cs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        cnt_d     = cnt_q;
        grant_w   = 1'b0;
        grant_r   = 1'b0;
        case (state_q)
            IDLE: begin
                // on a tie the writer wins only if the reader had the last grant
                if (bus.W_REQ && (!bus.R_REQ || last_rd_q)) begin
                    grant_w = 1'b1;
                end else if (bus.R_REQ) begin
                    grant_r = 1'b1;
                end
                if (grant_w) begin
                    state_d   = WR;
                    last_rd_d = 1'b0;
                end else if (grant_r) begin
                    state_d   = RD;
                    last_rd_d = 1'b1;
                end
            end
            WR:    state_d = IDLE;
            RD: begin
                state_d = RWAIT;
                cnt_d   = CW'(RD_LAT - 1);
            end
            RWAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_ack_d   = grant_w;
        r_ack_d   = grant_r;
        mem_cs_d  = grant_w || grant_r;
        mem_rw_d  = grant_r;
        mem_add_d = mem_add_q;
        mem_din_d = mem_din_q;
        r_data_d  = r_data_q;
        r_valid_d = 1'b0;
        busy_d    = (state_d != IDLE);
        if (grant_w) begin
            mem_add_d = bus.W_ADD;
            mem_din_d = bus.W_DATA;
        end
        if (grant_r) begin
            mem_add_d = bus.R_ADD;
        end
        if (state_q == RWAIT && cnt_q == '0) begin
            r_valid_d = 1'b1;
            r_data_d  = bus.MEM_DOUT;
        end
    end

    assign bus.W_ACK   = w_ack_q;
    assign bus.R_ACK   = r_ack_q;
    assign bus.R_VALID = r_valid_q;
    assign bus.R_DATA  = r_data_q;
    assign bus.BUSY    = busy_q;
    assign bus.MEM_ADD = mem_add_q;
    assign bus.MEM_DIN = mem_din_q;
    assign bus.MEM_RW  = mem_rw_q;
    assign bus.MEM_CS  = mem_cs_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level timing model checks every cycle of the
// RD_LAT=1 instance; directed checks cover both the RD_LAT=1 and RD_LAT=3 instances.
module tb_mem_arbiter;
    localparam int L1 = 1;
    localparam int L3 = 3;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.AW(6), .DW(15)) bus ();
    mem_arbiter_if #(.AW(6), .DW(15)) bus3 ();

    mem_arbiter #(.AW(6), .DW(15), .RD_LAT(L1)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
    mem_arbiter #(.AW(6), .DW(15), .RD_LAT(L3)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));

    // sample memories with the configured read latency
    logic [14:0] mem1 [64];
    logic [14:0] dout1;
    logic [14:0] mem3 [64];
    logic [14:0] p3 [3];

    always @(posedge CLK) begin
        if (bus.MEM_CS && !bus.MEM_RW) mem1[bus.MEM_ADD] <= bus.MEM_DIN;
        dout1 <= (bus.MEM_CS && bus.MEM_RW) ? mem1[bus.MEM_ADD] : 15'h0;
        if (bus3.MEM_CS && !bus3.MEM_RW) mem3[bus3.MEM_ADD] <= bus3.MEM_DIN;
        p3[0] <= (bus3.MEM_CS && bus3.MEM_RW) ? mem3[bus3.MEM_ADD] : 15'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus.MEM_DOUT  = dout1;
    assign bus3.MEM_DOUT = p3[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [41:0] act1;
    assign act1 = {bus.W_ACK, bus.R_ACK, bus.R_VALID, bus.BUSY, bus.MEM_CS, bus.MEM_RW,
                   bus.MEM_ADD, bus.MEM_DIN, bus.R_DATA};

    // Model: once idle, a write occupies 2 cycles and a read 2+L1; events are
    // scheduled into a small ring of future cycles, held values kept separately.
    int          cyc = 0;
    int          free_at = 0;
    bit          started = 1'b0;
    bit          last_w = 1'b0;
    logic [14:0] shadow [64];
    bit          s_wack [16], s_rack [16], s_rv [16], s_busy [16], s_cs [16], s_rw [16];
    bit          s_addv [16], s_dinv [16];
    logic [5:0]  s_add [16];
    logic [14:0] s_din [16], s_rd [16];
    logic [5:0]  e_add = '0;
    logic [14:0] e_din = '0, e_rd = '0;

    always @(negedge CLK) begin
        int  k, k1, kv;
        bit  gw, gr;
        k = cyc % 16;
        if (started) begin
            if (s_addv[k]) e_add = s_add[k];
            if (s_dinv[k]) e_din = s_din[k];
            if (s_rv[k])   e_rd  = s_rd[k];
            chk("cycle_outputs", 64'(act1),
                64'({s_wack[k], s_rack[k], s_rv[k], s_busy[k], s_cs[k], s_rw[k], e_add, e_din, e_rd}));
        end
        s_wack[k] = 0; s_rack[k] = 0; s_rv[k] = 0; s_busy[k] = 0; s_cs[k] = 0; s_rw[k] = 0;
        s_addv[k] = 0; s_dinv[k] = 0;
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                s_wack[i] = 0; s_rack[i] = 0; s_rv[i] = 0; s_busy[i] = 0; s_cs[i] = 0;
                s_rw[i] = 0; s_addv[i] = 0; s_dinv[i] = 0;
            end
            e_add = '0; e_din = '0; e_rd = '0;
            last_w = 1'b0;
            free_at = cyc + 1;
            started = 1'b1;
        end else if (started && cyc >= free_at) begin
            if (bus.W_REQ && bus.R_REQ) gw = !last_w;
            else                        gw = bus.W_REQ;
            gr = bus.R_REQ && !gw;
            k1 = (cyc + 1) % 16;
            if (gw) begin
                s_wack[k1] = 1; s_cs[k1] = 1; s_busy[k1] = 1;
                s_addv[k1] = 1; s_add[k1] = bus.W_ADD;
                s_dinv[k1] = 1; s_din[k1] = bus.W_DATA;
                shadow[bus.W_ADD] = bus.W_DATA;
                last_w = 1'b1;
                free_at = cyc + 2;
            end else if (gr) begin
                s_rack[k1] = 1; s_cs[k1] = 1; s_rw[k1] = 1; s_busy[k1] = 1;
                s_addv[k1] = 1; s_add[k1] = bus.R_ADD;
                for (int i = 2; i <= 1 + L1; i++) s_busy[(cyc + i) % 16] = 1;
                kv = (cyc + 2 + L1) % 16;
                s_rv[kv] = 1; s_rd[kv] = shadow[bus.R_ADD];
                last_w = 1'b0;
                free_at = cyc + 2 + L1;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [14:0] d);
        int n = 0;
        bus.W_REQ = 1'b1; bus.W_ADD = a; bus.W_DATA = d;
        @(negedge CLK);
        while (!bus.W_ACK && n < 20) begin @(negedge CLK); n++; end
        chk("wr_ack_seen", 64'(bus.W_ACK), 64'(1));
        step();
        bus.W_REQ = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [14:0] d);
        int n = 0;
        bus.R_REQ = 1'b1; bus.R_ADD = a;
        @(negedge CLK);
        while (!bus.R_ACK && n < 20) begin @(negedge CLK); n++; end
        chk("rd_ack_seen", 64'(bus.R_ACK), 64'(1));
        step();
        bus.R_REQ = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!bus.R_VALID && n < 20) begin @(negedge CLK); n++; end
        chk("rd_valid_seen", 64'(bus.R_VALID), 64'(1));
        d = bus.R_DATA;
        step();
    endtask

    initial begin
        int          n, ng;
        bit          grw [8];
        logic [14:0] d;
        RST = 1'b1;
        bus.W_REQ = 0;  bus.W_ADD = '0;  bus.W_DATA = '0;  bus.R_REQ = 0;  bus.R_ADD = '0;
        bus3.W_REQ = 0; bus3.W_ADD = '0; bus3.W_DATA = '0; bus3.R_REQ = 0; bus3.R_ADD = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // single write, grant at cycle T
        bus.W_REQ = 1'b1; bus.W_ADD = 6'd5; bus.W_DATA = 15'h1ABC;
        @(negedge CLK);
        chk("reset_idle", 64'({bus.BUSY, bus.W_ACK, bus.R_ACK, bus.MEM_CS, bus.R_DATA}), 64'(0));
        step();
        @(negedge CLK);
        chk("wr_issue", 64'({bus.W_ACK, bus.MEM_CS, bus.MEM_RW, bus.BUSY, bus.MEM_ADD, bus.MEM_DIN}),
            64'({1'b1, 1'b1, 1'b0, 1'b1, 6'd5, 15'h1ABC}));
        step();
        bus.W_REQ = 1'b0;
        @(negedge CLK);
        chk("wr_done", 64'({bus.W_ACK, bus.MEM_CS, bus.BUSY, bus.MEM_ADD, bus.MEM_DIN}),
            64'({1'b0, 1'b0, 1'b0, 6'd5, 15'h1ABC}));
        step();

        // read back, RD_LAT=1
        bus.R_REQ = 1'b1; bus.R_ADD = 6'd5;
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("rd_issue", 64'({bus.R_ACK, bus.MEM_CS, bus.MEM_RW, bus.R_VALID, bus.MEM_ADD}),
            64'({4'b1110, 6'd5}));
        step();
        bus.R_REQ = 1'b0;
        @(negedge CLK);
        chk("rd_wait", 64'({bus.R_ACK, bus.MEM_CS, bus.R_VALID, bus.BUSY}), 64'(4'b0001));
        step();
        @(negedge CLK);
        chk("rd_valid", 64'({bus.R_VALID, bus.BUSY, bus.R_DATA}), 64'({1'b1, 1'b0, 15'h1ABC}));
        step();
        @(negedge CLK);
        chk("rd_hold", 64'({bus.R_VALID, bus.R_DATA}), 64'({1'b0, 15'h1ABC}));
        step();

        // both held: grants alternate starting with the writer
        pulse_reset();
        bus.W_REQ = 1'b1; bus.W_ADD = 6'd10; bus.W_DATA = 15'h0A0A;
        bus.R_REQ = 1'b1; bus.R_ADD = 6'd5;
        ng = 0; n = 0;
        while (ng < 8 && n < 80) begin
            @(negedge CLK);
            if (bus.W_ACK || bus.R_ACK) begin
                grw[ng] = bus.W_ACK;
                ng++;
            end
            n++;
            step();
        end
        bus.W_REQ = 1'b0; bus.R_REQ = 1'b0;
        chk("alt_count", 64'(ng), 64'(8));
        for (int i = 0; i < 8; i++) chk("alt_grant", 64'(grw[i]), 64'(i % 2 == 0));
        repeat (6) step();

        // fill sweep then read-back
        for (int a = 0; a < 64; a++) do_write(6'(a), 15'(a) + 15'h100);
        for (int a = 0; a < 64; a++) begin
            do_read(6'(a), d);
            chk("sweep_data", 64'(d), 64'(15'(a) + 15'h100));
        end

        // reset during RWAIT of a read of address 7
        bus.R_REQ = 1'b1; bus.R_ADD = 6'd7;
        n = 0;
        @(negedge CLK);
        while (!bus.R_ACK && n < 20) begin @(negedge CLK); n++; end
        chk("rst_rd_ack", 64'(bus.R_ACK), 64'(1));
        step();
        bus.R_REQ = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_in_rwait", 64'({bus.BUSY, bus.MEM_CS}), 64'(2'b10));
        step();
        RST = 1'b0;
        bus.W_REQ = 1'b1; bus.W_ADD = 6'd20; bus.W_DATA = 15'h2020;
        bus.R_REQ = 1'b1; bus.R_ADD = 6'd5;
        @(negedge CLK);
        chk("rst_outputs", 64'(act1), 64'(0));
        step();
        @(negedge CLK);
        chk("rst_tie_writer", 64'({bus.W_ACK, bus.R_ACK}), 64'(2'b10));
        step();
        bus.W_REQ = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!bus.R_ACK && n < 20) begin @(negedge CLK); n++; end
        chk("rst_then_rd_ack", 64'(bus.R_ACK), 64'(1));
        step();
        bus.R_REQ = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!bus.R_VALID && n < 20) begin @(negedge CLK); n++; end
        chk("rst_then_rd_data", 64'({bus.R_VALID, bus.R_DATA}), 64'({1'b1, 15'h105}));
        step();

        // RD_LAT=3 instance: write then read address 9
        bus3.W_REQ = 1'b1; bus3.W_ADD = 6'd9; bus3.W_DATA = 15'h0999;
        n = 0;
        @(negedge CLK);
        while (!bus3.W_ACK && n < 20) begin @(negedge CLK); n++; end
        chk("l3_wr_ack", 64'(bus3.W_ACK), 64'(1));
        step();
        bus3.W_REQ = 1'b0;
        step();
        bus3.R_REQ = 1'b1; bus3.R_ADD = 6'd9;
        @(negedge CLK);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 2) bus3.R_REQ = 1'b0;
            @(negedge CLK);
            case (k)
                1:       chk("l3_issue", 64'({bus3.R_ACK, bus3.MEM_CS, bus3.R_VALID, bus3.BUSY}), 64'(4'b1101));
                5:       chk("l3_valid", 64'({bus3.R_ACK, bus3.MEM_CS, bus3.R_VALID, bus3.BUSY, bus3.R_DATA}),
                             64'({4'b0010, 15'h0999}));
                default: chk("l3_rwait", 64'({bus3.R_ACK, bus3.MEM_CS, bus3.R_VALID, bus3.BUSY}), 64'(4'b0001));
            endcase
        end
        step();
        @(negedge CLK);
        chk("l3_hold", 64'({bus3.R_VALID, bus3.R_DATA}), 64'({1'b0, 15'h0999}));

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
